// File: rtl/sr_ff_bank.sv
// Bank of WIDTH synchronous SR flip-flops sharing one enable. It has a selectable S=R=1 policy,
// per-channel conflict pulses, a sticky conflict flag and a saturating counter of edges on which q changed.
module sr_ff_bank #(
   parameter int unsigned       WIDTH = 8,
   parameter logic [WIDTH-1:0]  INIT  = '0,
   parameter int unsigned       CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] r,
   input  logic [1:0]       mode,
   input  logic             sticky_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_n,
   output logic [WIDTH-1:0] conflict,
   output logic             conflict_sticky,
   output logic             changed,
   output logic [CNT_W-1:0] change_cnt
);

   localparam logic [1:0]       MODE_HOLD   = 2'b00;
   localparam logic [1:0]       MODE_SET    = 2'b01;
   localparam logic [1:0]       MODE_RESET  = 2'b10;
   localparam logic [1:0]       MODE_TOGGLE = 2'b11;
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] conflict_next;
   logic             changed_next;
   logic             sticky_next;
   logic [CNT_W-1:0] cnt_next;

   // Per-channel next state; S=R=1 resolved by the mode sampled on this edge
   always_comb begin
      q_next = q;
      if (en) begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            case ({s[i], r[i]})
               2'b10:   q_next[i] = 1'b1;
               2'b01:   q_next[i] = 1'b0;
               2'b11: begin
                  case (mode)
                     MODE_HOLD:   q_next[i] = q[i];
                     MODE_SET:    q_next[i] = 1'b1;
                     MODE_RESET:  q_next[i] = 1'b0;
                     MODE_TOGGLE: q_next[i] = ~q[i];
                     default:     q_next[i] = q[i];
                  endcase
               end
               default: q_next[i] = q[i];
            endcase
         end
      end
   end

   // Conflict, change detection, sticky flag (a new conflict beats a clear) and saturating count
   always_comb begin
      conflict_next = '0;
      changed_next  = 1'b0;
      sticky_next   = conflict_sticky;
      cnt_next      = change_cnt;
      if (en) begin
         conflict_next = s & r;
         changed_next  = (q_next != q);
      end
      if (|conflict_next) begin
         sticky_next = 1'b1;
      end else if (sticky_clr) begin
         sticky_next = 1'b0;
      end
      if (changed_next && (change_cnt != CNT_MAX)) begin
         cnt_next = change_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q               <= INIT;
         q_n             <= ~INIT;
         conflict        <= '0;
         conflict_sticky <= 1'b0;
         changed         <= 1'b0;
         change_cnt      <= '0;
      end else begin
         q               <= q_next;
         q_n             <= ~q_next;
         conflict        <= conflict_next;
         conflict_sticky <= sticky_next;
         changed         <= changed_next;
         change_cnt      <= cnt_next;
      end
   end

endmodule
